// File: rtl/dma_axi_rd_if_pkg.sv
// Shared widths and bus payload types for the DMA AXI read front end.
package dma_axi_rd_if_pkg;

    localparam int unsigned DMA_ADDR_WIDTH = 32;
    localparam int unsigned DMA_DATA_WIDTH = 64;
    localparam int unsigned DMA_STRB_WIDTH = DMA_DATA_WIDTH / 8;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic {
        DMA_MODE_INCR  = 1'b0,
        DMA_MODE_FIXED = 1'b1
    } dma_mode_e;

    typedef struct packed {
        logic                      valid;
        logic [DMA_ADDR_WIDTH-1:0] addr;
        logic [7:0]                alen;
        logic [2:0]                size;
        logic [DMA_STRB_WIDTH-1:0] strb;
        dma_mode_e                 mode;
    } s_dma_axi_req_t;

    typedef struct packed {
        logic ready;
    } s_dma_axi_resp_t;

endpackage

// File: rtl/dma_axi_rd_if_if.sv
// AXI read address and read data channels between the DMA master and memory.
interface dma_axi_rd_if_if;

    logic                                           arvalid_o;
    logic                                           arready_i;
    logic [dma_axi_rd_if_pkg::DMA_ADDR_WIDTH-1:0]   araddr_o;
    logic [7:0]                                     arlen_o;
    logic [2:0]                                     arsize_o;
    logic [1:0]                                     arburst_o;
    logic                                           rvalid_i;
    logic                                           rready_o;
    logic [dma_axi_rd_if_pkg::DMA_DATA_WIDTH-1:0]   rdata_i;
    logic [1:0]                                     rresp_i;
    logic                                           rlast_i;

    modport master (
        output arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o, rready_o,
        input  arready_i, rvalid_i, rdata_i, rresp_i, rlast_i
    );

    modport slave (
        input  arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o, rready_o,
        output arready_i, rvalid_i, rdata_i, rresp_i, rlast_i
    );

endinterface

// File: rtl/dma_axi_rd_if.sv
// Read-side AXI master: issues AR bursts, tracks outstanding bursts, registers R beats.
module dma_axi_rd_if
    import dma_axi_rd_if_pkg::*;
#(
    parameter int unsigned MAX_OT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  s_dma_axi_req_t            dma_axi_req_i,
    output s_dma_axi_resp_t           dma_axi_resp_o,
    input  logic                      dma_abort_i,
    input  logic                      err_clr_i,
    dma_axi_rd_if_if.master           axi,
    output logic                      rd_valid_o,
    input  logic                      rd_ready_i,
    output logic [DMA_DATA_WIDTH-1:0] rd_data_o,
    output logic [DMA_STRB_WIDTH-1:0] rd_strb_o,
    output logic                      rd_error_o,
    output logic                      rd_idle_o
);

    localparam int unsigned PTR_W = $clog2(MAX_OT);
    localparam int unsigned CNT_W = $clog2(MAX_OT + 1);

    // OT queue storage: burst length and byte strobe per outstanding burst
    logic [7:0]                q_alen [MAX_OT];
    logic [DMA_STRB_WIDTH-1:0] q_strb [MAX_OT];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          ot_cnt;
    logic [7:0]                bcnt;

    logic                      req_ready_c;
    logic                      accept_c;
    logic                      rready_c;
    logic                      beat_c;
    logic                      q_empty_c;
    logic                      at_last_c;
    logic                      pop_c;
    logic                      err_c;
    logic [7:0]                head_alen_c;
    logic [DMA_STRB_WIDTH-1:0] head_strb_c;

    // Handshake decode, burst-end detection and error detection
    always_comb begin
        q_empty_c   = (ot_cnt == '0);
        head_alen_c = q_alen[rd_ptr];
        head_strb_c = q_strb[rd_ptr];
        req_ready_c = ~dma_abort_i & (~axi.arvalid_o | axi.arready_i)
                    & (ot_cnt < CNT_W'(MAX_OT));
        accept_c    = dma_axi_req_i.valid & req_ready_c;
        // Abort keeps R open so outstanding beats drain regardless of the sink
        rready_c    = dma_abort_i | ~rd_valid_o | rd_ready_i;
        beat_c      = axi.rvalid_i & rready_c;
        at_last_c   = ~q_empty_c & (bcnt == head_alen_c);
        pop_c       = beat_c & at_last_c;
        err_c       = beat_c & ((axi.rresp_i == 2'b10) | (axi.rresp_i == 2'b11) | q_empty_c
                    | (~q_empty_c & (axi.rlast_i != at_last_c)));
    end

    // Combinational outputs toward the streamer and the R channel
    always_comb begin
        dma_axi_resp_o       = '0;
        dma_axi_resp_o.ready = req_ready_c;
        axi.rready_o         = rready_c;
        rd_idle_o            = (ot_cnt == '0) & ~axi.arvalid_o;
    end

    // AR channel registers: hold until arready, reload on back-to-back accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            axi.arvalid_o <= 1'b0;
            axi.araddr_o  <= '0;
            axi.arlen_o   <= '0;
            axi.arsize_o  <= '0;
            axi.arburst_o <= '0;
        end else if (accept_c) begin
            axi.arvalid_o <= 1'b1;
            axi.araddr_o  <= dma_axi_req_i.addr;
            axi.arlen_o   <= dma_axi_req_i.alen;
            axi.arsize_o  <= dma_axi_req_i.size;
            axi.arburst_o <= (dma_axi_req_i.mode == DMA_MODE_FIXED) ? AXI_BURST_FIXED
                                                                    : AXI_BURST_INCR;
        end else if (axi.arready_i) begin
            axi.arvalid_o <= 1'b0;
        end
    end

    // OT queue write on request acceptance
    always_ff @(posedge clk) begin
        if (accept_c) begin
            q_alen[wr_ptr] <= dma_axi_req_i.alen;
            q_strb[wr_ptr] <= dma_axi_req_i.strb;
        end
    end

    // OT queue pointers, outstanding count and beat counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ot_cnt <= '0;
            bcnt   <= '0;
        end else begin
            if (accept_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept_c, pop_c})
                2'b10:   ot_cnt <= ot_cnt + CNT_W'(1);
                2'b01:   ot_cnt <= ot_cnt - CNT_W'(1);
                default: ot_cnt <= ot_cnt;
            endcase
            if (beat_c & ~q_empty_c) begin
                bcnt <= at_last_c ? 8'd0 : bcnt + 8'd1;
            end
        end
    end

    // One-entry output register; abort flushes and suppresses new beats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_strb_o  <= '0;
        end else if (dma_abort_i) begin
            rd_valid_o <= 1'b0;
        end else if (beat_c & ~q_empty_c) begin
            rd_valid_o <= 1'b1;
            rd_data_o  <= axi.rdata_i;
            rd_strb_o  <= head_strb_c;
        end else if (rd_ready_i) begin
            rd_valid_o <= 1'b0;
        end
    end

    // Sticky error flag; a new error wins over the clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_error_o <= 1'b0;
        end else if (err_c) begin
            rd_error_o <= 1'b1;
        end else if (err_clr_i) begin
            rd_error_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_axi_rd_if.sv
// Directed plus randomized bench for dma_axi_rd_if with a burst-level scoreboard.
module tb_dma_axi_rd_if;
    import dma_axi_rd_if_pkg::*;

    localparam int unsigned MAX_OT = 4;

    logic            clk = 1'b0;
    logic            rst;
    s_dma_axi_req_t  req;
    s_dma_axi_resp_t resp;
    logic            abort;
    logic            err_clr;
    logic            rd_valid;
    logic            rd_ready;
    logic [63:0]     rd_data;
    logic [7:0]      rd_strb;
    logic            rd_error;
    logic            rd_idle;

    dma_axi_rd_if_if axi ();

    dma_axi_rd_if #(.MAX_OT(MAX_OT)) dut (
        .clk            (clk),
        .rst            (rst),
        .dma_axi_req_i  (req),
        .dma_axi_resp_o (resp),
        .dma_abort_i    (abort),
        .err_clr_i      (err_clr),
        .axi            (axi),
        .rd_valid_o     (rd_valid),
        .rd_ready_i     (rd_ready),
        .rd_data_o      (rd_data),
        .rd_strb_o      (rd_strb),
        .rd_error_o     (rd_error),
        .rd_idle_o      (rd_idle)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding bursts, expected output beats and AR transfers
    int unsigned burst_len [$];
    logic [7:0]  burst_strb[$];
    int unsigned beat_idx = 0;
    bit          model_err = 1'b0;
    logic [71:0] exp_out[$];
    logic [71:0] got_out[$];
    logic [44:0] exp_ar[$];
    logic [44:0] got_ar[$];
    int          abort_valid_cnt = 0;
    bit          tog_en = 1'b0;
    bit          rand_en = 1'b0;
    bit          rand_ar_en = 1'b0;

    // Monitor: record output and AR handshakes, count outputs seen during abort
    always @(posedge clk) begin
        if (rd_valid && rd_ready) got_out.push_back({rd_data, rd_strb});
        if (axi.arvalid_o && axi.arready_i)
            got_ar.push_back({axi.araddr_o, axi.arlen_o, axi.arsize_o, axi.arburst_o});
        if (abort && rd_valid) abort_valid_cnt++;
    end

    // Sink and AR-ready pattern generators
    always @(posedge clk) begin
        #1;
        if (tog_en) rd_ready = ~rd_ready;
        else if (rand_en) rd_ready = 1'($urandom_range(0, 1));
        if (rand_ar_en) axi.arready_i = 1'($urandom_range(0, 1));
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [7:0] alen,
                            input logic [2:0] size, input logic [7:0] strb, input dma_mode_e mode);
        int n = 0;
        bit ok = 1'b0;
        req.valid = 1'b1; req.addr = addr; req.alen = alen;
        req.size = size; req.strb = strb; req.mode = mode;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = resp.ready;
            if (!ok) begin @(posedge clk); #1; n++; end
        end
        chk("req_accept", 72'(ok), 72'(1));
        @(posedge clk); #1;
        req.valid = 1'b0;
        if (ok) begin
            burst_len.push_back(int'(alen));
            burst_strb.push_back(strb);
            exp_ar.push_back({addr, alen, size, (mode == DMA_MODE_FIXED) ? 2'b00 : 2'b01});
            chk("arvalid_n1", 72'(axi.arvalid_o), 72'(1));
        end
    endtask

    task automatic send_beat(input logic [63:0] data, input logic [1:0] rr, input bit last);
        int n = 0;
        bit ok = 1'b0;
        bit matched = 1'b0;
        axi.rvalid_i = 1'b1; axi.rdata_i = data; axi.rresp_i = rr; axi.rlast_i = last;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = axi.rready_o;
            if (!ok) begin @(posedge clk); #1; n++; end
        end
        chk("r_accept", 72'(ok), 72'(1));
        @(posedge clk); #1;
        axi.rvalid_i = 1'b0; axi.rlast_i = 1'b0; axi.rresp_i = 2'b00;
        if (ok) begin
            if (rr[1]) model_err = 1'b1;
            if (burst_len.size() == 0) begin
                model_err = 1'b1;
            end else begin
                matched = 1'b1;
                if (last != (beat_idx == burst_len[0])) model_err = 1'b1;
                if (!abort) exp_out.push_back({data, burst_strb[0]});
                if (beat_idx == burst_len[0]) begin
                    void'(burst_len.pop_front());
                    void'(burst_strb.pop_front());
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
            chk("rd_error_m1", 72'(rd_error), 72'(model_err));
            if (matched && !abort) chk("rd_valid_m1", 72'(rd_valid), 72'(1));
            if (abort) chk("abort_rd_valid", 72'(rd_valid), 72'(0));
        end
    endtask

    task automatic send_burst(input int len, input int err_at);
        for (int i = 0; i <= len; i++)
            send_beat({$urandom, $urandom}, (i == err_at) ? 2'b10 : 2'b00, i == len);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        model_err = 1'b0;
        chk("err_clr", 72'(rd_error), 72'(0));
    endtask

    task automatic drain();
        logic [71:0] g;
        logic [71:0] e;
        tog_en = 1'b0; rand_en = 1'b0; rand_ar_en = 1'b0;
        rd_ready = 1'b1; axi.arready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("out_count", 72'(got_out.size()), 72'(exp_out.size()));
        while (got_out.size() > 0 && exp_out.size() > 0) begin
            g = got_out.pop_front(); e = exp_out.pop_front();
            chk("out_beat", g, e);
        end
        chk("ar_count", 72'(got_ar.size()), 72'(exp_ar.size()));
        while (got_ar.size() > 0 && exp_ar.size() > 0) begin
            g = 72'(got_ar.pop_front()); e = 72'(exp_ar.pop_front());
            chk("ar_fields", g, e);
        end
        chk("idle", 72'(rd_idle), 72'(burst_len.size() == 0));
        got_out.delete(); exp_out.delete(); got_ar.delete(); exp_ar.delete();
    endtask

    initial begin
        int lens[2];
        int k;
        rst = 1'b0; req = '0; abort = 1'b0; err_clr = 1'b0; rd_ready = 1'b1;
        axi.arready_i = 1'b1; axi.rvalid_i = 1'b0; axi.rdata_i = '0;
        axi.rresp_i = 2'b00; axi.rlast_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset values
        chk("rst_arvalid", 72'(axi.arvalid_o), 72'(0));
        chk("rst_araddr", 72'(axi.araddr_o), 72'(0));
        chk("rst_arlen", 72'(axi.arlen_o), 72'(0));
        chk("rst_arsize", 72'(axi.arsize_o), 72'(0));
        chk("rst_arburst", 72'(axi.arburst_o), 72'(0));
        chk("rst_rd_valid", 72'(rd_valid), 72'(0));
        chk("rst_rd_data", 72'(rd_data), 72'(0));
        chk("rst_rd_strb", 72'(rd_strb), 72'(0));
        chk("rst_rd_error", 72'(rd_error), 72'(0));
        chk("rst_ready", 72'(resp.ready), 72'(1));
        chk("rst_rready", 72'(axi.rready_o), 72'(1));
        chk("rst_idle", 72'(rd_idle), 72'(1));
        rst = 1'b1;
        @(posedge clk); #1;

        // Single INCR burst
        send_req(32'h1000, 8'd3, 3'd3, 8'hFF, DMA_MODE_INCR);
        send_burst(3, -1);
        drain();

        // Outstanding limit
        for (int i = 0; i < int'(MAX_OT); i++)
            send_req(32'h4000 + 32'(i * 64), 8'd0, 3'd3, 8'(8'h11 << i), DMA_MODE_INCR);
        @(negedge clk);
        chk("ot_full_ready", 72'(resp.ready), 72'(0));
        @(posedge clk); #1;
        send_beat(64'hA5A5_0000_1111_2222, 2'b00, 1'b1);
        chk("ready_after_pop", 72'(resp.ready), 72'(1));
        for (int i = 1; i < int'(MAX_OT); i++)
            send_beat({$urandom, $urandom}, 2'b00, 1'b1);
        drain();

        // FIXED single beat with partial strobe
        send_req(32'h2000, 8'd0, 3'd2, 8'h0C, DMA_MODE_FIXED);
        send_burst(0, -1);
        drain();

        // Error response still forwarded, then clear
        send_req(32'h3000, 8'd1, 3'd3, 8'hF0, DMA_MODE_INCR);
        send_burst(1, 0);
        drain();
        clear_err();

        // Early rlast on beat 1 of a 4-beat burst
        send_req(32'h3100, 8'd3, 3'd3, 8'hFF, DMA_MODE_INCR);
        send_beat(64'h1, 2'b00, 1'b0);
        send_beat(64'h2, 2'b00, 1'b1);
        send_beat(64'h3, 2'b00, 1'b0);
        send_beat(64'h4, 2'b00, 1'b1);
        drain();
        clear_err();

        // Abort with two 8-beat bursts outstanding
        send_req(32'h5000, 8'd7, 3'd3, 8'hFF, DMA_MODE_INCR);
        send_req(32'h5100, 8'd7, 3'd3, 8'hFF, DMA_MODE_INCR);
        abort_valid_cnt = 0;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_ready", 72'(resp.ready), 72'(0));
        @(posedge clk); #1;
        send_burst(7, -1);
        send_burst(7, -1);
        chk("abort_idle", 72'(rd_idle), 72'(1));
        chk("abort_no_valid", 72'(abort_valid_cnt), 72'(0));
        abort = 1'b0;
        #1;
        chk("abort_release_ready", 72'(resp.ready), 72'(1));
        drain();

        // Toggling sink backpressure over a 16-beat burst
        send_req(32'h6000, 8'd15, 3'd3, 8'h3C, DMA_MODE_INCR);
        tog_en = 1'b1;
        send_burst(15, -1);
        drain();

        // Reset in the middle of a burst
        send_req(32'h7000, 8'd3, 3'd3, 8'hFF, DMA_MODE_INCR);
        send_beat(64'h77, 2'b00, 1'b0);
        send_beat(64'h78, 2'b00, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_idle", 72'(rd_idle), 72'(1));
        chk("midrst_rd_valid", 72'(rd_valid), 72'(0));
        chk("midrst_arvalid", 72'(axi.arvalid_o), 72'(0));
        burst_len.delete(); burst_strb.delete(); beat_idx = 0; model_err = 1'b0;
        got_out.delete(); exp_out.delete(); got_ar.delete(); exp_ar.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with random sink and AR backpressure
        rand_en = 1'b1; rand_ar_en = 1'b1;
        for (int it = 0; it < 24; it++) begin
            k = int'($urandom_range(1, 2));
            for (int j = 0; j < k; j++) begin
                lens[j] = int'($urandom_range(0, 3));
                send_req($urandom, 8'(lens[j]), 3'($urandom_range(0, 3)), 8'($urandom),
                         dma_mode_e'($urandom_range(0, 1)));
            end
            for (int j = 0; j < k; j++)
                send_burst(lens[j], ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, lens[j])) : -1);
        end
        drain();
        clear_err();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
